// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scan controller: fetches a row pair from the framebuffer,
// shifts it out one bit plane at a time, latches it, then shows it for a binary-weighted window.
`timescale 1ns/1ps
module hub75_scan_ctrl #(
  parameter int COLS      = 64,
  parameter int ROW_BITS  = 5,
  parameter int BPP       = 4,
  parameter int BASE_TIME = 32
) (
  input  logic                              clk_25mhz,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic [7:0]                        brightness,
  output logic                              fb_rd_en,
  output logic [ROW_BITS+$clog2(COLS)-1:0]  fb_addr,
  input  logic [6*BPP-1:0]                  fb_data,
  output logic                              LP_CLK,
  output logic                              LATCH,
  output logic                              NOE,
  output logic [2:0]                        RGB0,
  output logic [2:0]                        RGB1,
  output logic [ROW_BITS-1:0]               ROW,
  output logic                              frame_done
);

  localparam int CW     = $clog2(COLS);
  localparam int PW     = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int WIN_W  = $clog2((BASE_TIME << (BPP - 1)) + 1);
  localparam int PROD_W = WIN_W + 8;
  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
  localparam logic [PW-1:0] LAST_PLANE = PW'(BPP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFETCH, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY
  } state_t;

  // Full brightness lights the whole window; otherwise window*brightness/256, truncated.
  function automatic logic [WIN_W-1:0] on_cycles(input logic [WIN_W-1:0] win,
                                                 input logic [7:0]       br);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(win) * PROD_W'(br);
    if (br == 8'hff) on_cycles = win;
    else             on_cycles = WIN_W'(prod >> 8);
  endfunction

  state_t                   state_q, state_d;
  logic                     phase_q, phase_d;
  logic [CW-1:0]            col_cnt_q, col_cnt_d;
  logic [ROW_BITS-1:0]      row_cnt_q, row_cnt_d;
  logic [PW-1:0]            bit_plane_q, bit_plane_d;
  logic [WIN_W-1:0]         disp_cnt_q, disp_cnt_d;
  logic [WIN_W-1:0]         on_q, on_d;
  logic [2:0]               rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic [ROW_BITS-1:0]      row_q, row_d;
  logic [ROW_BITS+CW-1:0]   fb_addr_q, fb_addr_d;
  logic                     lp_clk_q, lp_clk_d, latch_q, latch_d, noe_q, noe_d;
  logic                     fb_rd_en_q, fb_rd_en_d, frame_done_q, frame_done_d;

  logic [5:0][BPP-1:0]      chan;
  logic [WIN_W-1:0]         win;
  logic                     plane_last, row_last;
  logic [PW-1:0]            plane_nx;
  logic [ROW_BITS-1:0]      row_nx;

  assign chan       = fb_data;
  assign win        = WIN_W'(BASE_TIME) << bit_plane_q;
  assign plane_last = (bit_plane_q == LAST_PLANE);
  assign row_last   = (row_cnt_q == '1);
  assign plane_nx   = plane_last ? '0 : bit_plane_q + PW'(1);
  assign row_nx     = plane_last ? row_cnt_q + ROW_BITS'(1) : row_cnt_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    bit_plane_d  = bit_plane_q;
    disp_cnt_d   = disp_cnt_q;
    on_d         = on_q;
    rgb0_d       = rgb0_q;
    rgb1_d       = rgb1_q;
    row_d        = row_q;
    fb_addr_d    = fb_addr_q;
    lp_clk_d     = 1'b0;
    latch_d      = 1'b0;
    noe_d        = 1'b1;
    fb_rd_en_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d    = S_PREFETCH;
          fb_rd_en_d = 1'b1;
          fb_addr_d  = {row_cnt_q, {CW{1'b0}}};
          col_cnt_d  = '0;
          phase_d    = 1'b0;
        end
      end
      S_PREFETCH: begin
        state_d = S_SHIFT;
        phase_d = 1'b0;
      end
      S_SHIFT: begin
        // Data read last cycle is captured as LP_CLK rises; the next column is requested alongside.
        if (!phase_q) begin
          phase_d  = 1'b1;
          lp_clk_d = 1'b1;
          rgb0_d   = {chan[5][bit_plane_q], chan[4][bit_plane_q], chan[3][bit_plane_q]};
          rgb1_d   = {chan[2][bit_plane_q], chan[1][bit_plane_q], chan[0][bit_plane_q]};
          if (col_cnt_q != LAST_COL) begin
            fb_rd_en_d = 1'b1;
            fb_addr_d  = {row_cnt_q, col_cnt_q + CW'(1)};
          end
        end else if (col_cnt_q == LAST_COL) begin
          state_d = S_BLANK;
          phase_d = 1'b0;
          row_d   = row_cnt_q;
        end else begin
          col_cnt_d = col_cnt_q + CW'(1);
          phase_d   = 1'b0;
        end
      end
      S_BLANK: begin
        state_d = S_LATCH;
        latch_d = 1'b1;
      end
      S_LATCH: begin
        state_d    = S_DISPLAY;
        disp_cnt_d = '0;
        on_d       = on_cycles(win, brightness);
        noe_d      = (on_d == '0);
      end
      S_DISPLAY: begin
        if (disp_cnt_q == win - WIN_W'(1)) begin
          bit_plane_d = plane_nx;
          row_cnt_d   = row_nx;
          if (enable) begin
            state_d    = S_PREFETCH;
            fb_rd_en_d = 1'b1;
            fb_addr_d  = {row_nx, {CW{1'b0}}};
            col_cnt_d  = '0;
            phase_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          disp_cnt_d   = disp_cnt_q + WIN_W'(1);
          noe_d        = (disp_cnt_d >= on_q);
          frame_done_d = (disp_cnt_d == win - WIN_W'(1)) && plane_last && row_last;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      bit_plane_q  <= '0;
      disp_cnt_q   <= '0;
      on_q         <= '0;
      rgb0_q       <= '0;
      rgb1_q       <= '0;
      row_q        <= '0;
      fb_addr_q    <= '0;
      lp_clk_q     <= 1'b0;
      latch_q      <= 1'b0;
      noe_q        <= 1'b1;
      fb_rd_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      bit_plane_q  <= bit_plane_d;
      disp_cnt_q   <= disp_cnt_d;
      on_q         <= on_d;
      rgb0_q       <= rgb0_d;
      rgb1_q       <= rgb1_d;
      row_q        <= row_d;
      fb_addr_q    <= fb_addr_d;
      lp_clk_q     <= lp_clk_d;
      latch_q      <= latch_d;
      noe_q        <= noe_d;
      fb_rd_en_q   <= fb_rd_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fb_rd_en   = fb_rd_en_q;
  assign fb_addr    = fb_addr_q;
  assign LP_CLK     = lp_clk_q;
  assign LATCH      = latch_q;
  assign NOE        = noe_q;
  assign RGB0       = rgb0_q;
  assign RGB1       = rgb1_q;
  assign ROW        = row_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl: a plane-level reference model queues expected
// per-plane observations; a monitor reconstructs each plane from the panel pins and compares.
`timescale 1ns/1ps
module tb_hub75_scan_ctrl;
  localparam int COLS = 4, ROW_BITS = 1, BPP = 2, BASE_TIME = 8;
  localparam int CW = $clog2(COLS), ROWS = 1 << ROW_BITS, AW = ROW_BITS + CW;

  logic              clk, rst_n, enable;
  logic [7:0]        brightness;
  logic              fb_rd_en;
  logic [AW-1:0]     fb_addr;
  logic [6*BPP-1:0]  fb_data;
  logic              LP_CLK, LATCH, NOE, frame_done;
  logic [2:0]        RGB0, RGB1;
  logic [ROW_BITS-1:0] ROW;

  hub75_scan_ctrl #(.COLS(COLS), .ROW_BITS(ROW_BITS), .BPP(BPP), .BASE_TIME(BASE_TIME)) dut (
    .clk_25mhz(clk), .rst_n(rst_n), .enable(enable), .brightness(brightness),
    .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_data(fb_data),
    .LP_CLK(LP_CLK), .LATCH(LATCH), .NOE(NOE), .RGB0(RGB0), .RGB1(RGB1),
    .ROW(ROW), .frame_done(frame_done));

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    int row; int plane; int rgb0; int rgb1; int noe_low; int dur; int fd;
  } exp_t;

  int   checks = 0, errors = 0;
  int   mem [ROWS][COLS][6];
  exp_t exp_q[$];
  int   fd_times[$];
  int   pf_cnt = 0, cyc_total = 0;
  bit   mon_active = 1'b0;
  int   m_row = 0, m_plane = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(req));
    end
  endtask

  function automatic int on_model(int w, int br);
    return (br == 255) ? w : (w * br) / 256;
  endfunction

  function automatic logic [6*BPP-1:0] pixel(logic [AW-1:0] a);
    int r, c;
    logic [6*BPP-1:0] d;
    r = int'(a) / COLS;
    c = int'(a) % COLS;
    d = '0;
    for (int ch = 0; ch < 6; ch++) d = (d << BPP) | (6*BPP)'(mem[r][c][ch]);
    return d;
  endfunction

  task automatic fill_mem(input bit col_pattern);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int ch = 0; ch < 6; ch++)
          mem[r][c][ch] = (col_pattern && ch == 0) ? c : int'($urandom_range(0, (1 << BPP) - 1));
  endtask

  // Framebuffer: valid data only the cycle after a read strobe, junk otherwise.
  initial begin
    logic rd;
    logic [AW-1:0] ad;
    fb_data = '0;
    forever begin
      @(negedge clk);
      rd = fb_rd_en;
      ad = fb_addr;
      @(posedge clk);
      #1;
      if (rd === 1'b1) fb_data = pixel(ad);
      else             fb_data = (6*BPP)'($urandom);
    end
  end

  // Reference model: queue the expected observation of the next n planes.
  task automatic push_planes(input int n, input int br);
    exp_t e;
    int w, b0, b1;
    for (int i = 0; i < n; i++) begin
      w = BASE_TIME << m_plane;
      e.row = m_row; e.plane = m_plane; e.rgb0 = 0; e.rgb1 = 0;
      for (int c = 0; c < COLS; c++) begin
        b0 = 0; b1 = 0;
        for (int k = 0; k < 3; k++) begin
          b0 = b0 * 2 + ((mem[m_row][c][k]     >> m_plane) & 1);
          b1 = b1 * 2 + ((mem[m_row][c][k + 3] >> m_plane) & 1);
        end
        e.rgb0 += b0 << (3 * c);
        e.rgb1 += b1 << (3 * c);
      end
      e.noe_low = on_model(w, br);
      e.dur     = (i == n - 1) ? -1 : 1 + 2*COLS + 2 + w;
      e.fd      = (m_row == ROWS - 1 && m_plane == BPP - 1) ? 1 : 0;
      exp_q.push_back(e);
      if (m_plane == BPP - 1) begin m_plane = 0; m_row = (m_row + 1) % ROWS; end
      else m_plane++;
    end
  endtask

  int mon_cyc, mon_lp, mon_rgb0, mon_rgb1, mon_latch_off, mon_latch_cnt;
  int mon_noe_low, mon_fd_cnt, mon_fd_off, mon_row_lat;
  bit mon_in_plane, mon_noe_bad, mon_seen_high;
  logic mon_prev_lp;
  logic [ROW_BITS-1:0] mon_prev_row;

  task automatic emit(input int dur);
    exp_t e;
    string tag;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_plane: got row %0d with no plane expected", mon_row_lat);
      return;
    end
    e = exp_q.pop_front();
    tag = $sformatf("r%0dp%0d", e.row, e.plane);
    check({tag, "_row"}, mon_row_lat, e.row);
    check({tag, "_lp_edges"}, mon_lp, COLS);
    check({tag, "_rgb0_seq"}, mon_rgb0, e.rgb0);
    check({tag, "_rgb1_seq"}, mon_rgb1, e.rgb1);
    check({tag, "_latch_count"}, mon_latch_cnt, 1);
    check({tag, "_latch_offset"}, mon_latch_off, 2*COLS + 2);
    check({tag, "_noe_low"}, mon_noe_low, e.noe_low);
    check({tag, "_noe_shape_bad"}, 32'(mon_noe_bad), 0);
    check({tag, "_plane_len"}, dur, e.dur);
    check({tag, "_frame_done_cnt"}, mon_fd_cnt, e.fd);
    if (e.fd == 1 && mon_fd_cnt == 1)
      check({tag, "_frame_done_pos"}, mon_fd_off, 2*COLS + 2 + (BASE_TIME << e.plane));
  endtask

  // Monitor: reconstructs each plane from pins, sampling on the falling edge.
  initial begin
    mon_in_plane = 1'b0;
    mon_prev_lp = 1'b0;
    mon_prev_row = '0;
    forever begin
      @(negedge clk);
      cyc_total++;
      if (!mon_active) begin
        mon_in_plane = 1'b0;
        mon_prev_lp  = LP_CLK;
        mon_prev_row = ROW;
        continue;
      end
      if (ROW !== mon_prev_row) check("row_change_while_noe_high", 32'(NOE), 1);
      mon_prev_row = ROW;
      if (mon_in_plane) mon_cyc++;
      if (fb_rd_en === 1'b1 && LP_CLK === 1'b0) begin
        if (mon_in_plane) emit(mon_cyc);
        mon_in_plane = 1'b1; mon_cyc = 0; mon_lp = 0; mon_rgb0 = 0; mon_rgb1 = 0;
        mon_latch_off = -1; mon_latch_cnt = 0; mon_noe_low = 0; mon_noe_bad = 1'b0;
        mon_seen_high = 1'b0; mon_fd_cnt = 0; mon_fd_off = -1; mon_row_lat = -1;
        pf_cnt++;
      end
      if (mon_in_plane) begin
        if (LP_CLK === 1'b1 && mon_prev_lp === 1'b0) begin
          if (mon_lp < COLS) begin
            mon_rgb0 += int'(RGB0) << (3 * mon_lp);
            mon_rgb1 += int'(RGB1) << (3 * mon_lp);
          end
          mon_lp++;
        end
        if (LATCH === 1'b1) begin
          mon_latch_cnt++; mon_latch_off = mon_cyc; mon_row_lat = int'(ROW);
        end
        if (NOE !== 1'b1) begin
          if (mon_latch_off < 0 || mon_cyc <= mon_latch_off || mon_seen_high) mon_noe_bad = 1'b1;
          mon_noe_low++;
        end else if (mon_latch_off >= 0 && mon_cyc > mon_latch_off) begin
          mon_seen_high = 1'b1;
        end
        if (frame_done === 1'b1) begin
          mon_fd_cnt++; mon_fd_off = mon_cyc; fd_times.push_back(cyc_total);
        end
        if (mon_latch_off >= 0 && mon_cyc - mon_latch_off > 40) begin
          emit(-1);
          mon_in_plane = 1'b0;
        end
      end
      mon_prev_lp = LP_CLK;
    end
  end

  task automatic run_segment(input int n, input int br);
    int target;
    brightness = 8'(br);
    push_planes(n, br);
    target = pf_cnt + n;
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (pf_cnt >= target) break;
    end
    check("plane_starts", pf_cnt, target);
    enable = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) break;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int frame_len;
    rst_n = 1'b0; enable = 1'b1; brightness = 8'd255;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lp_clk", 32'(LP_CLK), 0);
    check("rst_latch", 32'(LATCH), 0);
    check("rst_noe", 32'(NOE), 1);
    check("rst_rgb0", 32'(RGB0), 0);
    check("rst_rgb1", 32'(RGB1), 0);
    check("rst_row", 32'(ROW), 0);
    check("rst_fb_rd_en", 32'(fb_rd_en), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    @(posedge clk); #2;
    enable = 1'b0; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_noe", 32'(NOE), 1);
    check("idle_fb_rd_en", 32'(fb_rd_en), 0);
    check("idle_lp_clk", 32'(LP_CLK), 0);
    @(posedge clk); #2;
    mon_active = 1'b1;

    frame_len = 0;
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < BPP; p++) frame_len += 1 + 2*COLS + 2 + (BASE_TIME << p);
    fill_mem(1'b1);
    fd_times.delete();
    run_segment(11, 255);
    if (fd_times.size() >= 2) check("frame_period", fd_times[1] - fd_times[0], frame_len);
    else                      check("frame_done_pulses", fd_times.size(), 2);

    fill_mem(1'b0); run_segment(6, 128);
    fill_mem(1'b0); run_segment(5, 0);
    fill_mem(1'b0); run_segment(8, int'($urandom_range(1, 254)));

    // Reset while the panel is lit.
    mon_active = 1'b0;
    brightness = 8'd255;
    enable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (NOE === 1'b0) break;
    end
    check("lit_before_reset_noe", 32'(NOE), 0);
    check("lit_before_reset_row", 32'(ROW), m_row);
    @(posedge clk); #2;
    rst_n = 1'b0; enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_noe", 32'(NOE), 1);
    check("midrst_row", 32'(ROW), 0);
    check("midrst_lp_clk", 32'(LP_CLK), 0);
    check("midrst_latch", 32'(LATCH), 0);
    check("midrst_rgb", 32'({RGB0, RGB1}), 0);
    check("midrst_fb", 32'({fb_rd_en, fb_addr}), 0);
    check("midrst_frame_done", 32'(frame_done), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    m_row = 0; m_plane = 0;
    @(posedge clk); #2;
    mon_active = 1'b1;
    fill_mem(1'b0); run_segment(4, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 Parameter COLS, default 64, columns shifted per row pair (>=2).
REQ-002 Parameter ROW_BITS, default 5, width of ROW; the panel has 2**ROW_BITS row pairs.
REQ-003 Parameter BPP, default 4, colour bits per channel (1..8).
REQ-004 Parameter BASE_TIME, default 32, display window in clocks for bit plane 0 (>=2).
REQ-005 clk_25mhz  in  1  system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 enable  in  1  scanning permitted while high.
REQ-008 brightness  in  8  global dimming; 0 = dark, 255 = full.
REQ-009 fb_rd_en  out  1  framebuffer read strobe.
REQ-010 fb_addr  out  ROW_BITS+clog2(COLS)  read address {row, col}.
REQ-011 fb_data  in  6*BPP  {r0,g0,b0,r1,g1,b1}, BPP bits each; valid exactly 1 clock after fb_rd_en.
REQ-012 LP_CLK  out  1  panel shift clock.
REQ-013 LATCH  out  1  panel latch strobe.
REQ-014 NOE  out  1  panel output enable, active-low.
REQ-015 RGB0  out  3  {r,g,b} upper-half bit for the current column/plane.
REQ-016 RGB1  out  3  {r,g,b} lower-half bit for the current column/plane.
REQ-017 ROW  out  ROW_BITS  displayed row-pair address.
REQ-018 frame_done  out  1  one-clock pulse when the last plane of the last row finishes display.

Function
REQ-019 The FSM SHALL have states IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE -> PREFETCH when enable=1.
- PREFETCH: 1 clock; fb_rd_en=1, fb_addr={row_cnt,0}.
- SHIFT: 2 clocks per column. Phase 0: LP_CLK=0; RGB0/RGB1 load bit[bit_plane] of each fb_data channel. Phase 1: LP_CLK=1; fb_rd_en=1 for the next column unless col=COLS-1.
- After phase 1 of col COLS-1 -> BLANK.
- BLANK: 1 clock; NOE=1; ROW <= row_cnt.
- LATCH: 1 clock; LATCH=1, NOE=1.
- DISPLAY: exactly BASE_TIME<<bit_plane clocks.
REQ-020 In DISPLAY, NOE SHALL be 0 for the first on_cycles clocks and 1 for the remainder.
- on_cycles = window if brightness=255.
- Otherwise on_cycles = floor(window*brightness/256).
- brightness is sampled on entry to DISPLAY.
REQ-021 Scan order SHALL be: for each row_cnt 0..2**ROW_BITS-1, bit_plane 0..BPP-1. After the last plane, row_cnt increments; after the last row it wraps to 0 and frame_done pulses for the final DISPLAY clock.
REQ-022 Per-plane duration SHALL be 1 + 2*COLS + 2 + (BASE_TIME<<bit_plane) clocks; there is no overlap of shift and display.
REQ-023 enable deasserted mid-plane SHALL let the current plane complete through DISPLAY, then enter IDLE. row_cnt and bit_plane are retained, and resume occurs at the next plane.
REQ-024 In IDLE, outputs SHALL be: NOE=1, LP_CLK=0, LATCH=0, fb_rd_en=0.
REQ-025 ROW SHALL change only in BLANK, so a row never changes while NOE=0.
REQ-026 LP_CLK, LATCH and NOE SHALL be registered outputs, glitch-free.

Reset
REQ-027 When rst_n=0 at a clock edge, the following SHALL hold the next cycle, regardless of state:
- state=IDLE, LP_CLK=0, LATCH=0, NOE=1, RGB0=RGB1=0, ROW=0.
- fb_rd_en=0, fb_addr=0, frame_done=0.
- row_cnt=0, col_cnt=0, bit_plane=0.
REQ-028 No output SHALL be X after the first reset edge.

Verification (COLS=4, ROW_BITS=1, BPP=2, BASE_TIME=8)
REQ-029 Reset during DISPLAY with NOE=0 -> the next cycle has NOE=1, state=IDLE, ROW=0, all other outputs 0.
REQ-030 enable=1, brightness=255, fb_data constant -> 4 LP_CLK rising edges per plane.
- Plane 0 lasts 19 clocks with NOE low for 8.
- Plane 1 lasts 27 clocks with NOE low for 16.
- frame_done pulses every 92 clocks.
REQ-031 fb returns r0 = col index (bit0) per address -> the RGB0[2] sequence at the LP_CLK rising edges is 0,1,0,1 for plane 0 and 0,0,1,1 for plane 1.
REQ-032 Brightness checks:
- brightness=128 -> NOE low 4 of 8 clocks (plane 0) and 8 of 16 (plane 1).
- brightness=0 -> NOE never low.
REQ-033 enable dropped in SHIFT of row 1 plane 0 -> that plane completes (latch + 8 display clocks), then IDLE. Re-enable -> the first LATCH occurs at row 1 plane 1.
REQ-034 Across the full run, ROW changes only when NOE=1, and fb_data is sampled only 1 clock after fb_rd_en.
